// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, word type, Rcon and GF(2^8) helpers.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  // Round constant for rounds 1..10; index 0 and 11..15 never occur in use.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// SubWord: the S-box applied independently to each byte of a 32-bit word.
module key_sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .in_byte  (word_in[8*g +: 8]),
      .out_byte (word_out[8*g +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] x3, x7, x15, x31, x63, x127, inv;

  always_comb begin
    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    x3   = gf_mul(gf_mul(in_byte, in_byte), in_byte);
    x7   = gf_mul(gf_mul(x3, x3), in_byte);
    x15  = gf_mul(gf_mul(x7, x7), in_byte);
    x31  = gf_mul(gf_mul(x15, x15), in_byte);
    x63  = gf_mul(gf_mul(x31, x31), in_byte);
    x127 = gf_mul(gf_mul(x63, x63), in_byte);
    inv  = gf_mul(x127, x127);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: presents round keys 0..10, one per accepted handshake beat.
module key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done
);

  // Handshake: a beat transfers on a rising edge where rk_valid and rk_ready are both 1;
  // while rk_valid=1 and rk_ready=0 the round key and index are held unchanged.

  ks_state_e    state_q, state_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic         done_q, done_d;

  word_t w0, w1, w2, w3, rot_w3, sub_w3, temp;
  word_t n0, n1, n2, n3;

  assign w0     = rk_out_q[127:96];
  assign w1     = rk_out_q[95:64];
  assign w2     = rk_out_q[63:32];
  assign w3     = rk_out_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  key_sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign temp = sub_w3 ^ {rcon(rk_round_q + 4'd1), 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_comb begin
    state_d    = state_q;
    rk_round_d = rk_round_q;
    rk_out_d   = rk_out_q;
    done_d     = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (start) begin
          state_d    = KS_RUN;
          rk_out_d   = key_in;
          rk_round_d = 4'd0;
        end
      end
      KS_RUN: begin
        if (rk_ready) begin
          if (rk_round_q == 4'(NR)) begin
            state_d = KS_IDLE;
            done_d  = 1'b1;
          end else begin
            rk_out_d   = {n0, n1, n2, n3};
            rk_round_d = rk_round_q + 4'd1;
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= KS_IDLE;
      rk_round_q <= 4'd0;
      rk_out_q   <= 128'h0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_round_q <= rk_round_d;
      rk_out_q   <= rk_out_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = (state_q == KS_RUN);
  assign busy     = (state_q == KS_RUN);
  assign rk_round = rk_round_q;
  assign rk_out   = rk_out_q;
  assign done     = done_q;

endmodule
